// File: rtl/wb_pkg.sv
// Shared definitions for the writeback stage.
//   result_src_e : result select encoding (ALU, load, PC+4, immediate)
//   Funct3*      : load size/sign codes understood by load_formatter
//   wb_state_e   : entry-register state
//   wb_entry_t   : captured instruction fields held between MEM and WB
package wb_pkg;

    typedef enum logic [1:0] {
        SrcAlu  = 2'b00,
        SrcLoad = 2'b01,
        SrcPc4  = 2'b10,
        SrcImm  = 2'b11
    } result_src_e;

    localparam logic [2:0] Funct3Lb  = 3'b000;
    localparam logic [2:0] Funct3Lh  = 3'b001;
    localparam logic [2:0] Funct3Lw  = 3'b010;
    localparam logic [2:0] Funct3Lbu = 3'b100;
    localparam logic [2:0] Funct3Lhu = 3'b101;

    typedef enum logic [1:0] {
        StEmpty    = 2'b00,
        StReady    = 2'b01,
        StWaitLoad = 2'b10
    } wb_state_e;

    typedef struct packed {
        logic [4:0]  rd;
        logic        reg_write;
        result_src_e result_src;
        logic [31:0] alu_result;
        logic [31:0] pc_plus4;
        logic [31:0] imm_ext;
        logic [2:0]  funct3;
    } wb_entry_t;

endpackage

// File: rtl/load_formatter.sv
// Combinational load-data formatter.
//   funct3 : load size/sign code (LB/LH/LW/LBU/LHU; unused codes act as LW)
//   offset : byte offset of the access within the word
//   rdata  : raw 32-bit word returned by memory
//   value  : selected and sign/zero-extended load result
module load_formatter
    import wb_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] rdata,
    output logic [31:0] value
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        case (offset)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
    end

    // Halfword access ignores offset[0]; misaligned halves are not split.
    assign half_sel = offset[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        value = rdata;
        case (funct3)
            Funct3Lb:  value = {{24{byte_sel[7]}}, byte_sel};
            Funct3Lbu: value = {24'h000000, byte_sel};
            Funct3Lh:  value = {{16{half_sel[15]}}, half_sel};
            Funct3Lhu: value = {16'h0000, half_sel};
            default:   value = rdata;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: one-entry buffer between MEM and the register file.
//   clk, rst_n                  : clock, asynchronous active-low reset
//   in_valid / in_ready         : MEM handshake; in_* fields captured on accept
//   in_rd, in_reg_write,
//   in_result_src, in_funct3,
//   in_alu_result, in_pc_plus4,
//   in_imm_ext                  : instruction fields and candidate results
//   mem_rvalid, mem_rdata       : load data return (only used while waiting on a load)
//   wb_we, wb_addr, wb_data     : register-file write port
//   fwd_valid, fwd_rd, fwd_data : bypass to execute, mirrors the write port
//   a0                          : registered shadow of x10
//   retired                     : wrapping count of retired instructions
module writeback_stage
    import wb_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_rd,
    input  logic        in_reg_write,
    input  logic [1:0]  in_result_src,
    input  logic [31:0] in_alu_result,
    input  logic [31:0] in_pc_plus4,
    input  logic [31:0] in_imm_ext,
    input  logic [2:0]  in_funct3,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        wb_we,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data,
    output logic        fwd_valid,
    output logic [4:0]  fwd_rd,
    output logic [31:0] fwd_data,
    output logic [31:0] a0,
    output logic [31:0] retired
);

    wb_state_e   state_q, state_d;
    wb_entry_t   entry_q, entry_d;
    logic [31:0] a0_q, a0_d;
    logic [31:0] retired_q, retired_d;

    logic        retire;
    logic        accept;
    logic [31:0] load_value;
    logic [31:0] result;

    load_formatter u_load_formatter (
        .funct3 (entry_q.funct3),
        .offset (entry_q.alu_result[1:0]),
        .rdata  (mem_rdata),
        .value  (load_value)
    );

    // An entry leaves in READY at once, or in WAIT_LOAD when its data arrives.
    always_comb begin
        retire = 1'b0;
        case (state_q)
            StReady:    retire = 1'b1;
            StWaitLoad: retire = mem_rvalid;
            default:    retire = 1'b0;
        endcase
    end

    assign in_ready = (state_q == StEmpty) || retire;
    assign accept   = in_valid && in_ready;

    always_comb begin
        result = entry_q.alu_result;
        case (entry_q.result_src)
            SrcAlu:  result = entry_q.alu_result;
            SrcLoad: result = load_value;
            SrcPc4:  result = entry_q.pc_plus4;
            SrcImm:  result = entry_q.imm_ext;
            default: result = entry_q.alu_result;
        endcase
    end

    assign wb_we   = retire && entry_q.reg_write && (entry_q.rd != 5'd0);
    assign wb_addr = entry_q.rd;
    assign wb_data = result;

    assign fwd_valid = wb_we;
    assign fwd_rd    = wb_addr;
    assign fwd_data  = wb_data;

    always_comb begin
        state_d   = state_q;
        entry_d   = entry_q;
        a0_d      = a0_q;
        retired_d = retired_q;

        if (retire) begin
            state_d   = StEmpty;
            retired_d = retired_q + 32'd1;
        end

        // A same-cycle accept overrides the EMPTY transition from retire.
        if (accept) begin
            entry_d.rd         = in_rd;
            entry_d.reg_write  = in_reg_write;
            entry_d.result_src = result_src_e'(in_result_src);
            entry_d.alu_result = in_alu_result;
            entry_d.pc_plus4   = in_pc_plus4;
            entry_d.imm_ext    = in_imm_ext;
            entry_d.funct3     = in_funct3;
            state_d = (result_src_e'(in_result_src) == SrcLoad) ? StWaitLoad : StReady;
        end

        if (wb_we && (wb_addr == 5'd10)) begin
            a0_d = wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StEmpty;
            entry_q   <= '0;
            a0_q      <= 32'd0;
            retired_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            entry_q   <= entry_d;
            a0_q      <= a0_d;
            retired_q <= retired_d;
        end
    end

    assign a0      = a0_q;
    assign retired = retired_q;

endmodule
